// File: rtl/video_timing_detect.sv
// video_timing_detect: receive-side sync/DE analyser. Recovers per-pixel
// coordinates and a frame-start pulse, measures frame geometry and tracks
// whether the incoming timing is stable.
module video_timing_detect #(
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             de_in,
   output logic             pix_valid,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic             frame_start,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_active,
   output logic             locked,
   output logic             timing_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int unsigned      MW      = $clog2(LOCK_FRAMES + 1);
   localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t           state, state_nx;
   logic [MW-1:0]    match_cnt, match_nx;
   logic             err_nx, snap_en;

   logic             hs_d, vs_d, de_d;
   logic             hs_rise, vs_rise, de_rise, de_fall;
   logic [CNT_W-1:0] cnt_h, cnt_v, de_run, de_lines, line_len, line_act;
   logic [CNT_W-1:0] ll_new, la_new, fl_new;
   logic             first_de, h_sat, snap_same;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign hs_rise = hsync_in & ~hs_d;
   assign vs_rise = vsync_in & ~vs_d;
   assign de_rise = de_in & ~de_d;
   assign de_fall = ~de_in & de_d;
   assign h_sat   = (cnt_h == CNT_MAX);

   // Values as they stand after this cycle's edges, so a snapshot taken on
   // the same clock as an hsync edge or DE fall sees the completed figures.
   assign ll_new    = hs_rise ? sat_inc(cnt_h) : line_len;
   assign la_new    = de_fall ? de_run : line_act;
   assign fl_new    = sat_inc(cnt_v);
   assign snap_same = ({ll_new, fl_new, la_new, de_lines} ==
                       {h_total, v_total, h_active, v_active}) &&
                      ({h_total, v_total, h_active, v_active} != '0);

   // Delayed copies of the sync/DE inputs for edge detection.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hs_d <= 1'b0;
         vs_d <= 1'b0;
         de_d <= 1'b0;
      end else begin
         hs_d <= hsync_in;
         vs_d <= vsync_in;
         de_d <= de_in;
      end
   end

   // Horizontal clock counter and length of the last completed line.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h    <= '0;
         line_len <= '0;
      end else if (hs_rise) begin
         cnt_h    <= '0;
         line_len <= ll_new;
      end else begin
         cnt_h    <= sat_inc(cnt_h);
      end
   end

   // Line counter within the frame; a frame edge beats a line edge.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)   cnt_v <= '0;
      else if (vs_rise) cnt_v <= '0;
      else if (hs_rise) cnt_v <= sat_inc(cnt_v);
   end

   // DE run length per line and count of DE lines per frame.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_run   <= '0;
         line_act <= '0;
         de_lines <= '0;
      end else begin
         if (de_rise)     de_run <= CNT_W'(1);
         else if (de_in)  de_run <= sat_inc(de_run);
         if (de_fall)     line_act <= de_run;
         if (vs_rise)     de_lines <= '0;
         else if (de_rise) de_lines <= sat_inc(de_lines);
      end
   end

   // Pixel coordinates and frame-start pulse, one clock behind the inputs.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         first_de    <= 1'b1;
      end else begin
         pix_valid   <= de_in;
         frame_start <= vs_rise;
         if (de_rise)    pix_x <= '0;
         else if (de_in) pix_x <= sat_inc(pix_x);
         if (de_rise)    pix_y <= first_de ? '0 : sat_inc(pix_y);
         if (vs_rise)      first_de <= 1'b1;
         else if (de_rise) first_de <= 1'b0;
      end
   end

   // Frame geometry snapshot, refreshed on every frame edge outside SEARCH.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_total  <= '0;
         v_total  <= '0;
         h_active <= '0;
         v_active <= '0;
      end else if (snap_en) begin
         h_total  <= ll_new;
         v_total  <= fl_new;
         h_active <= la_new;
         v_active <= de_lines;
      end
   end

   // Lock FSM state register with registered status outputs.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= SEARCH;
         match_cnt  <= '0;
         locked     <= 1'b0;
         timing_err <= 1'b0;
      end else begin
         state      <= state_nx;
         match_cnt  <= match_nx;
         locked     <= (state_nx == LOCKED);
         timing_err <= err_nx;
      end
   end

   // Lock FSM next state; a stalled line counter overrides everything.
   always_comb begin
      state_nx = state;
      match_nx = match_cnt;
      err_nx   = 1'b0;
      snap_en  = vs_rise && (state != SEARCH);
      if (h_sat) begin
         state_nx = SEARCH;
         err_nx   = (state == LOCKED);
      end else begin
         case (state)
            SEARCH: begin
               if (vs_rise) begin
                  state_nx = CHECK;
                  match_nx = '0;
               end
            end
            CHECK: begin
               if (vs_rise) begin
                  if (snap_same) begin
                     match_nx = match_cnt + MW'(1);
                     if (match_cnt + MW'(1) >= LOCK_N) state_nx = LOCKED;
                  end else begin
                     match_nx = '0;
                  end
               end
            end
            LOCKED: begin
               if ((hs_rise && (ll_new != h_total)) || (vs_rise && !snap_same)) begin
                  state_nx = CHECK;
                  match_nx = '0;
                  err_nx   = 1'b1;
               end
            end
            default: begin
               state_nx = SEARCH;
               match_nx = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_timing_detect.sv
// tb_video_timing_detect: drives generated sync/DE streams (fixed and random
// geometries, long lines, hsync loss, mid-frame reset) and checks every output
// each cycle against a timestamp-based reference model.
module tb_video_timing_detect;

   localparam int CNT_W    = 12;
   localparam int MAXV     = (1 << CNT_W) - 1;
   localparam int LOCKN    = 2;
   localparam int BIG      = 1000000;
   localparam int M_SEARCH = 0;
   localparam int M_CHECK  = 1;
   localparam int M_LOCKED = 2;

   typedef struct {
      int htot; int hsw; int hds; int hdl;
      int vtot; int vsw; int vds; int vdl;
   } geo_t;

   logic             vga_clk   = 1'b0;
   logic             sys_rst_n = 1'b0;
   logic             hsync_in  = 1'b0;
   logic             vsync_in  = 1'b0;
   logic             de_in     = 1'b0;
   logic             pix_valid, frame_start, locked, timing_err;
   logic [CNT_W-1:0] pix_x, pix_y, h_total, v_total, h_active, v_active;

   int compared   = 0;
   int mismatched = 0;

   // reference model state
   int cyc, t_hs, t_de, nh, m_dl, m_ll, m_la, mode, match, first;
   int p_hs, p_vs, p_de;
   int m_valid, m_x, m_y, m_fs, m_lock, m_err;
   int e_ht, e_vt, e_ha, e_va;

   // observed-stream statistics
   int fs_cnt, err_cnt = 0, pv_cnt, got_first, first_x, first_y, last_x, last_y;
   int lock_seen = 0, lock_cyc = -1;

   geo_t ga, gb;

   video_timing_detect #(.CNT_W(CNT_W), .LOCK_FRAMES(LOCKN)) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start),
      .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
      .locked(locked), .timing_err(timing_err)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         if (mismatched <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc = 0; t_hs = -1; t_de = 0; nh = 0; m_dl = 0; m_ll = 0; m_la = 0;
      mode = M_SEARCH; match = 0; first = 1;
      p_hs = 0; p_vs = 0; p_de = 0;
      m_valid = 0; m_x = 0; m_y = 0; m_fs = 0; m_lock = 0; m_err = 0;
      e_ht = 0; e_vt = 0; e_ha = 0; e_va = 0;
   endtask

   // One clock of the model: line/frame lengths from edge timestamps.
   task automatic model_step(input int hs, input int vs, input int de);
      int hr, vr, dr, df, sat, same, snap, ll_new, la_new, fl_new;
      hr = hs && !p_hs; vr = vs && !p_vs; dr = de && !p_de; df = !de && p_de;
      sat    = (imin(cyc - t_hs - 1, MAXV) == MAXV);
      ll_new = hr ? imin(cyc - t_hs, MAXV) : m_ll;
      la_new = df ? imin(cyc - t_de, MAXV) : m_la;
      fl_new = imin(nh + 1, MAXV);
      same   = (ll_new == e_ht) && (fl_new == e_vt) && (la_new == e_ha) && (m_dl == e_va)
               && ((e_ht | e_vt | e_ha | e_va) != 0);
      snap   = vr && (mode != M_SEARCH);
      m_err  = 0;
      if (sat) begin
         if (mode == M_LOCKED) m_err = 1;
         mode = M_SEARCH;
      end else if (mode == M_SEARCH) begin
         if (vr) begin mode = M_CHECK; match = 0; end
      end else if (mode == M_CHECK) begin
         if (vr) begin
            match = same ? match + 1 : 0;
            if (match >= LOCKN) mode = M_LOCKED;
         end
      end else begin
         if ((hr && ll_new != e_ht) || (vr && !same)) begin
            mode = M_CHECK; match = 0; m_err = 1;
         end
      end
      if (snap) begin e_ht = ll_new; e_vt = fl_new; e_ha = la_new; e_va = m_dl; end
      m_lock  = (mode == M_LOCKED);
      m_valid = de;
      m_fs    = vr;
      if (dr) begin t_de = cyc; m_y = first ? 0 : imin(m_y + 1, MAXV); end
      if (de) m_x = imin(cyc - t_de, MAXV);
      if (vr) first = 1; else if (dr) first = 0;
      if (hr) begin m_ll = ll_new; t_hs = cyc; end
      if (df) m_la = la_new;
      nh   = vr ? 0 : (hr ? imin(nh + 1, MAXV) : nh);
      m_dl = vr ? 0 : (dr ? imin(m_dl + 1, MAXV) : m_dl);
      p_hs = hs; p_vs = vs; p_de = de;
      cyc++;
   endtask

   // Model advances on every clock the DUT is out of reset.
   always @(posedge vga_clk) begin
      if (sys_rst_n) model_step(int'(hsync_in), int'(vsync_in), int'(de_in));
   end

   // Compare every output against the model and gather stream statistics.
   always @(negedge vga_clk) begin
      check("pix_valid",   int'(pix_valid),   m_valid);
      check("pix_x",       int'(pix_x),       m_x);
      check("pix_y",       int'(pix_y),       m_y);
      check("frame_start", int'(frame_start), m_fs);
      check("h_total",     int'(h_total),     e_ht);
      check("v_total",     int'(v_total),     e_vt);
      check("h_active",    int'(h_active),    e_ha);
      check("v_active",    int'(v_active),    e_va);
      check("locked",      int'(locked),      m_lock);
      check("timing_err",  int'(timing_err),  m_err);
      if (frame_start) fs_cnt++;
      if (timing_err)  err_cnt++;
      if (pix_valid) begin
         if (!got_first) begin got_first = 1; first_x = int'(pix_x); first_y = int'(pix_y); end
         last_x = int'(pix_x); last_y = int'(pix_y); pv_cnt++;
      end
      if (locked && !lock_seen) begin lock_seen = 1; lock_cyc = cyc - 1; end
   end

   task automatic clear_stats();
      fs_cnt = 0; pv_cnt = 0; got_first = 0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
   endtask

   task automatic drive_frame(input geo_t g, input int long_line, input int max_cyc);
      int n = 0;
      for (int v = 0; v < g.vtot; v++) begin
         for (int h = 0; h < ((v == long_line) ? g.htot + 1 : g.htot); h++) begin
            if (n == max_cyc) return;
            @(negedge vga_clk);
            sys_rst_n = 1'b1;
            hsync_in  = (h < g.hsw);
            vsync_in  = (v < g.vsw);
            de_in     = (h >= g.hds) && (h < g.hds + g.hdl) && (v >= g.vds) && (v < g.vds + g.vdl);
            n++;
         end
      end
   endtask

   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge vga_clk);
         hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pix_valid"}, int'(pix_valid), 0);
      check({tag, "_pix_x"},     int'(pix_x), 0);
      check({tag, "_pix_y"},     int'(pix_y), 0);
      check({tag, "_h_total"},   int'(h_total), 0);
      check({tag, "_v_active"},  int'(v_active), 0);
      check({tag, "_locked"},    int'(locked), 0);
      check({tag, "_timing_err"}, int'(timing_err), 0);
   endtask

   task automatic do_reset();
      @(negedge vga_clk);
      #2;
      sys_rst_n = 1'b0;
      model_reset();
      hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
      #1;
      check_all_zero("async_rst");
      lock_seen = 0; lock_cyc = -1;
      repeat (3) @(negedge vga_clk);
   endtask

   task automatic check_geo(input string tag, input int ht, input int vt, input int ha, input int va);
      check({tag, "_h_total"},  int'(h_total),  ht);
      check({tag, "_v_total"},  int'(v_total),  vt);
      check({tag, "_h_active"}, int'(h_active), ha);
      check({tag, "_v_active"}, int'(v_active), va);
   endtask

   initial begin
      geo_t gr;
      int   ll;
      model_reset();
      clear_stats();
      ga = '{htot: 40, hsw: 4, hds: 10, hdl: 24, vtot: 20, vsw: 2, vds: 3, vdl: 16};
      gb = '{htot: 30, hsw: 3, hds: 6,  hdl: 20, vtot: 16, vsw: 2, vds: 2, vdl: 12};

      // power-up: vsync high on the first cycle after reset
      repeat (3) @(negedge vga_clk);
      check_all_zero("por");
      repeat (4) drive_frame(ga, -1, BIG);
      #2;
      clear_stats();
      drive_frame(ga, -1, BIG);
      #2;
      check("lock_cycle", lock_cyc, 2400);
      check("lock_a", int'(locked), 1);
      check_geo("geo_a", 40, 20, 24, 16);
      check("pix_count", pv_cnt, 384);
      check("first_x", first_x, 0);
      check("first_y", first_y, 0);
      check("last_x", last_x, 23);
      check("last_y", last_y, 15);
      check("fs_per_frame", fs_cnt, 1);
      check("err_none", err_cnt, 0);

      // one over-long line while locked
      drive_frame(ga, 10, BIG);
      #2;
      check("err_long_line", err_cnt, 1);
      check("unlock_long_line", int'(locked), 0);
      repeat (3) drive_frame(ga, -1, BIG);
      #2;
      check("relock_long_line", int'(locked), 1);
      check("err_after_relock", err_cnt, 1);

      // hsync lost long enough to saturate the line counter
      drive_idle(4200);
      #2;
      check("unlock_no_hsync", int'(locked), 0);
      check("err_no_hsync", err_cnt, 2);
      check("h_total_kept", int'(h_total), 40);
      repeat (5) drive_frame(ga, -1, BIG);
      #2;
      check("relock_no_hsync", int'(locked), 1);

      // format change
      repeat (5) drive_frame(gb, -1, BIG);
      #2;
      check("err_format", err_cnt, 3);
      check_geo("geo_b", 30, 16, 20, 12);
      check("lock_b", int'(locked), 1);

      // random geometries with occasional long lines
      for (int r = 0; r < 3; r++) begin
         gr.htot = int'($urandom_range(48, 24));
         gr.hsw  = int'($urandom_range(4, 2));
         gr.hds  = gr.hsw + int'($urandom_range(3, 1));
         gr.hdl  = int'($urandom_range(gr.htot - gr.hds - 1, 4));
         gr.vtot = int'($urandom_range(20, 10));
         gr.vsw  = int'($urandom_range(3, 1));
         gr.vds  = gr.vsw + int'($urandom_range(2, 0));
         gr.vdl  = int'($urandom_range(gr.vtot - gr.vds - 1, 2));
         for (int f = 0; f < 5; f++) begin
            ll = -1;
            if ($urandom_range(3, 0) == 0) ll = int'($urandom_range(gr.vtot - 1, 0));
            drive_frame(gr, ll, BIG);
         end
      end

      // mid-line reset while locked, then relock from scratch
      repeat (6) drive_frame(ga, -1, BIG);
      #2;
      check("lock_before_rst", int'(locked), 1);
      drive_frame(ga, -1, 295);
      do_reset();
      repeat (5) drive_frame(ga, -1, BIG);
      #2;
      check("relock_cycle_rst", lock_cyc, 2400);
      check("lock_after_rst", int'(locked), 1);
      check_geo("geo_after_rst", 40, 20, 24, 16);

      repeat (2) @(negedge vga_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
